// File: rtl/cond_branch_unit.sv
// cond_branch_unit: icc register, Bicc cond decode and delay-slot annul tracking.
// Define CC_BYPASS_EN to forward same-cycle ALU flags into the branch decode.
module cond_branch_unit #(
  parameter logic [3:0] ICC_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cc_we,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_c,
  input  logic       br_valid,
  input  logic [3:0] cond,
  input  logic       annul_bit,
  input  logic       slot_valid,
  output logic [3:0] icc,
  output logic       cond_base,
  output logic       cond_inv,
  output logic       br_done,
  output logic       annul_slot,
  output logic       br_busy
);
  typedef enum logic {IDLE, SLOT} state_t;
  state_t state_q, state_d;
  logic [3:0] icc_q, icc_d, src, alu;
  logic [7:0] dec;
  logic cond_base_q, cond_base_d, cond_inv_q, cond_inv_d;
  logic br_done_q, br_done_d, annul_slot_q, annul_slot_d, br_busy_q, br_busy_d;
  logic base, take, slot_end;
  assign alu = {alu_n, alu_z, alu_v, alu_c};
`ifdef CC_BYPASS_EN
  assign src = (cc_we && br_valid) ? alu : icc_q;
`else
  assign src = icc_q;
`endif
  // src is {N,Z,V,C}; dec is indexed directly by cond[2:0]
  assign dec = {src[1], src[3], src[0], src[0] | src[2], src[3] ^ src[1],
                src[2] | (src[3] ^ src[1]), src[2], 1'b0};
  always_comb begin
    base         = dec[cond[2:0]];
    take         = (state_q == IDLE) && br_valid;
    slot_end     = (state_q == SLOT) && slot_valid;
    icc_d        = (cc_we && !((state_q == SLOT) && annul_slot_q)) ? alu : icc_q;
    state_d      = take ? SLOT : slot_end ? IDLE : state_q;
    cond_base_d  = take ? base : cond_base_q;
    cond_inv_d   = take ? cond[3] : cond_inv_q;
    br_done_d    = take;
    annul_slot_d = take ? annul_bit && ((cond[2:0] == 3'b000) || !(base ^ cond[3])) :
                   slot_end ? 1'b0 : annul_slot_q;
    br_busy_d    = take || (br_busy_q && !slot_end);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      icc_q        <= ICC_RESET;
      cond_base_q  <= 1'b0;
      cond_inv_q   <= 1'b0;
      br_done_q    <= 1'b0;
      annul_slot_q <= 1'b0;
      br_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      icc_q        <= icc_d;
      cond_base_q  <= cond_base_d;
      cond_inv_q   <= cond_inv_d;
      br_done_q    <= br_done_d;
      annul_slot_q <= annul_slot_d;
      br_busy_q    <= br_busy_d;
    end
  end
  assign icc        = icc_q;
  assign cond_base  = cond_base_q;
  assign cond_inv   = cond_inv_q;
  assign br_done    = br_done_q;
  assign annul_slot = annul_slot_q;
  assign br_busy    = br_busy_q;
endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: vector table plus a cond x icc sweep, checked through an expectation queue.
module tb_cond_branch_unit;
  logic clk = 1'b0;
  logic reset, cc_we, alu_n, alu_z, alu_v, alu_c, br_valid, annul_bit, slot_valid;
  logic [3:0] cond, icc;
  logic cond_base, cond_inv, br_done, annul_slot, br_busy;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  cond_branch_unit dut (
    .clk(clk), .reset(reset), .cc_we(cc_we), .alu_n(alu_n), .alu_z(alu_z),
    .alu_v(alu_v), .alu_c(alu_c), .br_valid(br_valid), .cond(cond),
    .annul_bit(annul_bit), .slot_valid(slot_valid), .icc(icc),
    .cond_base(cond_base), .cond_inv(cond_inv), .br_done(br_done),
    .annul_slot(annul_slot), .br_busy(br_busy)
  );
  // exp = {icc[3:0], cond_base, cond_inv, br_done, annul_slot, br_busy}
  typedef struct packed {
    logic rst, cc;
    logic [3:0] nzvc;
    logic bv;
    logic [3:0] cnd;
    logic a, sv;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [8:0] sb[$];
`ifdef CC_BYPASS_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif
  function automatic vec_t mk(input logic rst, input logic cc, input logic [3:0] nzvc,
                              input logic bv, input logic [3:0] cnd, input logic a,
                              input logic sv, input logic [8:0] exp);
    mk = '{rst, cc, nzvc, bv, cnd, a, sv, exp};
  endfunction
  function automatic logic ref_base(input logic [3:0] f, input logic [2:0] c);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      3'd0: ref_base = 1'b0;
      3'd1: ref_base = z;
      3'd2: ref_base = z | (n ^ v);
      3'd3: ref_base = n ^ v;
      3'd4: ref_base = cy | z;
      3'd5: ref_base = cy;
      3'd6: ref_base = n;
      default: ref_base = v;
    endcase
  endfunction
  task automatic step(input string name, input vec_t v);
    logic [8:0] act, exp;
    reset = v.rst; cc_we = v.cc; {alu_n, alu_z, alu_v, alu_c} = v.nzvc;
    br_valid = v.bv; cond = v.cnd; annul_bit = v.a; slot_valid = v.sv;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    act = {icc, cond_base, cond_inv, br_done, annul_slot, br_busy};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got icc/base/inv/done/annul/busy=%b required %b", name, act, exp);
  endtask
  initial begin
    logic pb, pi, b, an;
    logic [3:0] cv;
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0, {4'b0000, 5'b00000}));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0, {4'b0000, 5'b00000}));
    tbl.push_back(mk(0, 1, 4'h4, 0, 4'h0, 0, 0, {4'b0100, 5'b00000}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h1, 1, 0, {4'b0100, 5'b10101}));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 0, {4'b0100, 5'b10001}));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 1, {4'b0100, 5'b10000}));
    tbl.push_back(mk(0, 1, 4'h0, 0, 4'h0, 0, 0, {4'b0000, 5'b10000}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h9, 0, 0, {4'b0000, 5'b01101}));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 1, {4'b0000, 5'b01000}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h1, 1, 0, {4'b0000, 5'b00111}));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 1, {4'b0000, 5'b00000}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h8, 1, 0, {4'b0000, 5'b01111}));
    tbl.push_back(mk(0, 1, 4'hf, 0, 4'h0, 0, 0, {4'b0000, 5'b01011}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h8, 0, 0, {4'b0000, 5'b01011}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h1, 0, 1, {4'b0000, 5'b01000}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h9, 0, 1, {4'b0000, 5'b01101}));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 1, {4'b0000, 5'b01000}));
    tbl.push_back(mk(0, 1, 4'h4, 1, 4'h1, 1, 0, {4'b0100, HZ, 1'b0, 1'b1, ~HZ, 1'b1}));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 1, {4'b0100, HZ, 1'b0, 3'b000}));
    tbl.push_back(mk(0, 1, 4'hf, 0, 4'h0, 0, 0, {4'b1111, HZ, 1'b0, 3'b000}));
    tbl.push_back(mk(0, 0, 4'h0, 1, 4'h6, 0, 0, {4'b1111, 5'b10101}));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 0, {4'b0000, 5'b00000}));
    tbl.push_back(mk(1, 1, 4'hf, 1, 4'h1, 1, 1, {4'b0000, 5'b00000}));
    tbl.push_back(mk(0, 0, 4'h0, 0, 4'h0, 0, 1, {4'b0000, 5'b00000}));
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);
    pb = 1'b0;
    pi = 1'b0;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        cv = 4'(c);
        b = ref_base(4'(f), cv[2:0]);
        an = (cv[2:0] == 3'b000) || !(b ^ cv[3]);
        step($sformatf("load_icc%0d", f), mk(0, 1, 4'(f), 0, 4'h0, 0, 0, {4'(f), pb, pi, 3'b000}));
        step($sformatf("br_icc%0d_cond%0d", f, c), mk(0, 0, 4'h0, 1, cv, 1, 0, {4'(f), b, cv[3], 1'b1, an, 1'b1}));
        step($sformatf("slot_icc%0d_cond%0d", f, c), mk(0, 0, 4'h0, 0, 4'h0, 0, 1, {4'(f), b, cv[3], 3'b000}));
        pb = b;
        pi = cv[3];
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
